// File: rtl/hit_ring_mc_if.sv
// Record port of the multi-channel ring counter.
// Carries one {channel, ring, peak} record per valid/ready transfer toward the
// hit-parameter packer.
//   ph_vld  : record valid (producer)
//   ph_rdy  : record accepted when ph_vld & ph_rdy (consumer)
//   ph_ch   : channel index of the record
//   ph_ring : ring count of the record
//   ph_peak : peak sample of the record
interface hit_ring_mc_if #(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int CHW = 2
);
  logic           ph_vld;
  logic           ph_rdy;
  logic [CHW-1:0] ph_ch;
  logic [CW-1:0]  ph_ring;
  logic [DW-1:0]  ph_peak;

  modport master (output ph_vld, output ph_ch, output ph_ring, output ph_peak,
                  input  ph_rdy);
  modport slave  (input  ph_vld, input  ph_ch, input  ph_ring, input  ph_peak,
                  output ph_rdy);
endinterface

// File: rtl/hit_ring_mc.sv
// Multi-channel hit ring counter.
// Per channel: counts upward threshold crossings (rings) of the sample stream
// while the hit window is open, with hysteresis re-arm and a dead time after
// each counted ring, and tracks the peak sample. When the hit window closes the
// channel posts a {ring, peak} record; a round-robin arbiter moves posted
// records onto a single valid/ready record port.
// Ports:
//   clk_sys, rst_n     : clock, asynchronous active-low reset
//   sm_data / sm_vld   : per-channel samples (ch i at [i*DW +: DW]) and strobes
//   cfg_th / cfg_hyst  : crossing threshold and re-arm hysteresis below it
//   cfg_dead           : valid samples ignored after a counted ring
//   stu_now_hit        : hit window open, per channel
//   stu_now_lock       : hold the counters while outside the hit window
//   force_end          : drop the records of hits ending this cycle
//   stu_ring           : last completed ring count per channel
//   stu_ovf / ovf_clr  : sticky record-overwrite flags and their clear pulse
//   ph                 : record port (master side)
module hit_ring_mc #(
  parameter int DW  = 16,
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] sm_data,
  input  logic [NCH-1:0]    sm_vld,
  input  logic [DW-1:0]     cfg_th,
  input  logic [DW-1:0]     cfg_hyst,
  input  logic [7:0]        cfg_dead,
  input  logic [NCH-1:0]    stu_now_hit,
  input  logic [NCH-1:0]    stu_now_lock,
  input  logic              force_end,
  output logic [NCH*CW-1:0] stu_ring,
  output logic [NCH-1:0]    stu_ovf,
  input  logic              ovf_clr,
  hit_ring_mc_if.master     ph
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CW'(1) : v;
  endfunction

  // Per-channel state
  logic [NCH-1:0] hit_d_q, armed_q, armed_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [DW-1:0]  peak_q [NCH];
  logic [DW-1:0]  peak_d [NCH];
  logic [7:0]     dead_q [NCH];
  logic [7:0]     dead_d [NCH];
  logic [CW-1:0]  ring_q [NCH];
  logic [CW-1:0]  ring_d [NCH];
  logic [CW-1:0]  rec_ring_q [NCH];
  logic [CW-1:0]  rec_ring_d [NCH];
  logic [DW-1:0]  rec_peak_q [NCH];
  logic [DW-1:0]  rec_peak_d [NCH];

  // Record queue / arbiter state
  logic [NCH-1:0] pend_q, pend_d, ovf_q, ovf_d;
  logic           ph_vld_q, ph_vld_d;
  logic [CHW-1:0] ph_ch_q, ph_ch_d, rr_q, rr_d;
  logic [CW-1:0]  ph_ring_q, ph_ring_d;
  logic [DW-1:0]  ph_peak_q, ph_peak_d;
  // Displayed channel was re-posted after its record was loaded, so its
  // acceptance must not retire the newer record still waiting in the slot.
  logic           refr_q, refr_d;

  logic [DW-1:0]  rearm_lvl;
  logic [DW-1:0]  smp;
  logic [NCH-1:0] rise, fall, xing, post;

  assign rearm_lvl = sat_sub(cfg_th, cfg_hyst);

  always_comb begin
    smp  = '0;
    rise = '0;
    fall = '0;
    xing = '0;
    post = '0;
    armed_d = armed_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]      = cnt_q[i];
      peak_d[i]     = peak_q[i];
      dead_d[i]     = dead_q[i];
      ring_d[i]     = ring_q[i];
      rec_ring_d[i] = rec_ring_q[i];
      rec_peak_d[i] = rec_peak_q[i];
      smp     = sm_data[i*DW +: DW];
      rise[i] = stu_now_hit[i] & ~hit_d_q[i];
      fall[i] = ~stu_now_hit[i] & hit_d_q[i];
      xing[i] = sm_vld[i] & armed_q[i] & (smp >= cfg_th) & (dead_q[i] == 8'd0);
      post[i] = fall[i] & ~force_end;

      if (rise[i]) begin
        cnt_d[i]   = CW'(1);
        peak_d[i]  = smp;
        armed_d[i] = 1'b0;
        dead_d[i]  = cfg_dead;
      end else if (stu_now_hit[i]) begin
        if (sm_vld[i]) begin
          cnt_d[i] = sat_inc(cnt_q[i], xing[i]);
          if (smp > peak_q[i]) peak_d[i] = smp;
          if (xing[i]) begin
            armed_d[i] = 1'b0;
            dead_d[i]  = cfg_dead;
          end else begin
            if (dead_q[i] != 8'd0) dead_d[i] = dead_q[i] - 8'd1;
            if (smp < rearm_lvl)   armed_d[i] = 1'b1;
          end
        end
      end else if (!stu_now_lock[i]) begin
        cnt_d[i]   = '0;
        peak_d[i]  = '0;
        armed_d[i] = 1'b1;
        dead_d[i]  = '0;
      end

      if (fall[i]) ring_d[i] = cnt_q[i];
      if (post[i]) begin
        rec_ring_d[i] = cnt_q[i];
        rec_peak_d[i] = peak_q[i];
      end
    end
  end

  logic           acc, clr_ok, found;
  logic [NCH-1:0] cand;
  logic [CHW-1:0] sel;
  int             idx;

  always_comb begin
    acc    = ph_vld_q & ph.ph_rdy;
    clr_ok = acc & ~refr_q;
    cand   = pend_q;
    if (clr_ok) cand[ph_ch_q] = 1'b0;
    pend_d = cand | post;
    // A post onto a slot still holding an unaccepted record overwrites it.
    ovf_d  = (ovf_q & ~{NCH{ovf_clr}}) | (post & cand);

    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_q) + k) % NCH;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = CHW'(idx);
      end
    end

    ph_vld_d  = ph_vld_q;
    ph_ch_d   = ph_ch_q;
    ph_ring_d = ph_ring_q;
    ph_peak_d = ph_peak_q;
    rr_d      = rr_q;
    refr_d    = refr_q;
    if (!ph_vld_q || acc) begin
      ph_vld_d = found;
      refr_d   = 1'b0;
      if (found) begin
        ph_ch_d   = sel;
        ph_ring_d = rec_ring_q[sel];
        ph_peak_d = rec_peak_q[sel];
        rr_d      = sel;
        refr_d    = post[sel];
      end
    end else begin
      refr_d = refr_q | post[ph_ch_q];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hit_d_q   <= '0;
      armed_q   <= '1;
      pend_q    <= '0;
      ovf_q     <= '0;
      ph_vld_q  <= 1'b0;
      ph_ch_q   <= '0;
      ph_ring_q <= '0;
      ph_peak_q <= '0;
      rr_q      <= '0;
      refr_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= '0;
        peak_q[i]     <= '0;
        dead_q[i]     <= '0;
        ring_q[i]     <= '0;
        rec_ring_q[i] <= '0;
        rec_peak_q[i] <= '0;
      end
    end else begin
      hit_d_q   <= stu_now_hit;
      armed_q   <= armed_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      ph_vld_q  <= ph_vld_d;
      ph_ch_q   <= ph_ch_d;
      ph_ring_q <= ph_ring_d;
      ph_peak_q <= ph_peak_d;
      rr_q      <= rr_d;
      refr_q    <= refr_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        peak_q[i]     <= peak_d[i];
        dead_q[i]     <= dead_d[i];
        ring_q[i]     <= ring_d[i];
        rec_ring_q[i] <= rec_ring_d[i];
        rec_peak_q[i] <= rec_peak_d[i];
      end
    end
  end

  always_comb begin
    stu_ring = '0;
    for (int i = 0; i < NCH; i++) stu_ring[i*CW +: CW] = ring_q[i];
  end

  assign stu_ovf    = ovf_q;
  assign ph.ph_vld  = ph_vld_q;
  assign ph.ph_ch   = ph_ch_q;
  assign ph.ph_ring = ph_ring_q;
  assign ph.ph_peak = ph_peak_q;
endmodule

// File: tb/tb_hit_ring_mc.sv
module tb_hit_ring_mc;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int CHW = 2;

  logic              clk_sys = 1'b0;
  logic              rst_n   = 1'b1;
  logic [NCH*DW-1:0] sm_data;
  logic [NCH-1:0]    sm_vld;
  logic [DW-1:0]     cfg_th, cfg_hyst;
  logic [7:0]        cfg_dead;
  logic [NCH-1:0]    stu_now_hit, stu_now_lock;
  logic              force_end, ovf_clr;
  logic [NCH*CW-1:0] stu_ring;
  logic [NCH-1:0]    stu_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  hit_ring_mc_if #(.DW(DW), .CW(CW), .CHW(CHW)) ph_if ();

  hit_ring_mc #(.DW(DW), .NCH(NCH), .CW(CW)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .sm_data      (sm_data),
    .sm_vld       (sm_vld),
    .cfg_th       (cfg_th),
    .cfg_hyst     (cfg_hyst),
    .cfg_dead     (cfg_dead),
    .stu_now_hit  (stu_now_hit),
    .stu_now_lock (stu_now_lock),
    .force_end    (force_end),
    .stu_ring     (stu_ring),
    .stu_ovf      (stu_ovf),
    .ovf_clr      (ovf_clr),
    .ph           (ph_if)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] v, input logic h);
    sm_data[ch*DW +: DW] = v;
    sm_vld[ch]           = 1'b1;
    stu_now_hit[ch]      = h;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic accept();
    ph_if.ph_rdy = 1'b1;
    tick();
    ph_if.ph_rdy = 1'b0;
  endtask

  // Quiet sample, five in-window samples (first one opens the hit), then close.
  // Returns just after the closing edge.
  task automatic play_hit(input int ch, input logic [DW-1:0] a, b, c, d, e);
    set_ch(ch, 16'd50, 1'b0); tick();
    set_ch(ch, a, 1'b1); tick();
    set_ch(ch, b, 1'b1); tick();
    set_ch(ch, c, 1'b1); tick();
    set_ch(ch, d, 1'b1); tick();
    set_ch(ch, e, 1'b1); tick();
    set_ch(ch, 16'd0, 1'b0); tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak} !== '0)
      $display("FAIL reset_ph got %0b/%0d/%0d/%0d want all 0", ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    if (stu_ring !== '0 || stu_ovf !== '0)
      $display("FAIL reset_stu got ring %h ovf %b want 0", stu_ring, stu_ovf);
    else n_pass++;
    n_chk++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    if (ph_if.ph_vld !== 1'b0) $display("FAIL reset_idle ph_vld got %0b want 0", ph_if.ph_vld);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_ring();
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    do_reset();
    play_hit(0, 16'd120, 16'd95, 16'd105, 16'd85, 16'd110);
    if (stu_ring[0 +: CW] !== 4'd2) $display("FAIL ring_stu got %0d want 2", stu_ring[0 +: CW]);
    else n_pass++;
    n_chk++;
    if (ph_if.ph_vld !== 1'b0) $display("FAIL ring_latency ph_vld got %0b want 0", ph_if.ph_vld);
    else n_pass++;
    n_chk++;
    tick();
    if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak} !== {1'b1, 2'd0, 4'd2, 16'd120})
      $display("FAIL ring_rec got vld %0b ch %0d ring %0d peak %0d want 1/0/2/120", ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    accept();
    if (ph_if.ph_vld !== 1'b0) $display("FAIL ring_accept ph_vld got %0b want 0", ph_if.ph_vld);
    else n_pass++;
    n_chk++;
    // Narrow hysteresis, crossings landing exactly on the threshold.
    cfg_hyst = 16'd3;
    play_hit(0, 16'd120, 16'd95, 16'd100, 16'd85, 16'd100);
    tick();
    if ({ph_if.ph_ring, ph_if.ph_peak} !== {4'd3, 16'd120})
      $display("FAIL ring_eq_th got ring %0d peak %0d want 3/120", ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    accept();
  endtask

  task automatic test_hyst();
    cfg_th = 16'd100; cfg_hyst = 16'd30; cfg_dead = 8'd0;
    do_reset();
    play_hit(0, 16'd120, 16'd95, 16'd105, 16'd85, 16'd110);
    tick();
    if (ph_if.ph_ring !== 4'd1) $display("FAIL hyst30 got ring %0d want 1", ph_if.ph_ring);
    else n_pass++;
    n_chk++;
    accept();
    cfg_hyst = 16'd200;
    play_hit(0, 16'd120, 16'd0, 16'd130, 16'd0, 16'd140);
    tick();
    if ({ph_if.ph_ring, ph_if.ph_peak} !== {4'd1, 16'd140})
      $display("FAIL hyst_sat got ring %0d peak %0d want 1/140", ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    accept();
  endtask

  task automatic test_dead();
    cfg_th = 16'd100; cfg_hyst = 16'd3; cfg_dead = 8'd4;
    do_reset();
    play_hit(0, 16'd120, 16'd95, 16'd105, 16'd85, 16'd110);
    tick();
    if (ph_if.ph_ring !== 4'd1) $display("FAIL dead4 got ring %0d want 1", ph_if.ph_ring);
    else n_pass++;
    n_chk++;
    accept();
    cfg_dead = 8'd1;
    play_hit(0, 16'd120, 16'd95, 16'd100, 16'd85, 16'd100);
    tick();
    if (ph_if.ph_ring !== 4'd3) $display("FAIL dead1 got ring %0d want 3", ph_if.ph_ring);
    else n_pass++;
    n_chk++;
    accept();
  endtask

  task automatic test_sat();
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    do_reset();
    set_ch(0, 16'd120, 1'b1); tick();
    for (int k = 0; k < 19; k++) begin
      set_ch(0, 16'd50, 1'b1);  tick();
      set_ch(0, 16'd120, 1'b1); tick();
    end
    set_ch(0, 16'd0, 1'b0); tick();
    if (stu_ring[0 +: CW] !== 4'd15) $display("FAIL sat_stu got %0d want 15", stu_ring[0 +: CW]);
    else n_pass++;
    n_chk++;
    tick();
    if ({ph_if.ph_vld, ph_if.ph_ring, ph_if.ph_peak} !== {1'b1, 4'd15, 16'd120})
      $display("FAIL sat_rec got vld %0b ring %0d peak %0d want 1/15/120", ph_if.ph_vld, ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    accept();
  endtask

  task automatic test_back_to_back();
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    do_reset();
    ph_if.ph_rdy = 1'b1;
    set_ch(1, 16'd120, 1'b1); set_ch(2, 16'd130, 1'b1); set_ch(3, 16'd140, 1'b1); tick();
    set_ch(1, 16'd50, 1'b1);  set_ch(2, 16'd50, 1'b1);  set_ch(3, 16'd50, 1'b1);  tick();
    set_ch(1, 16'd60, 1'b1);  set_ch(2, 16'd150, 1'b1); set_ch(3, 16'd200, 1'b1); tick();
    set_ch(1, 16'd0, 1'b0);   set_ch(2, 16'd0, 1'b0);   set_ch(3, 16'd0, 1'b0);   tick();
    if (stu_ring !== 16'h2210) $display("FAIL b2b_stu got %h want 2210", stu_ring);
    else n_pass++;
    n_chk++;
    tick();
    if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak} !== {1'b1, 2'd1, 4'd1, 16'd120})
      $display("FAIL b2b_rec1 got vld %0b ch %0d ring %0d peak %0d want 1/1/1/120", ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    tick();
    if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak} !== {1'b1, 2'd2, 4'd2, 16'd150})
      $display("FAIL b2b_rec2 got vld %0b ch %0d ring %0d peak %0d want 1/2/2/150", ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    tick();
    if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak} !== {1'b1, 2'd3, 4'd2, 16'd200})
      $display("FAIL b2b_rec3 got vld %0b ch %0d ring %0d peak %0d want 1/3/2/200", ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    tick();
    if (ph_if.ph_vld !== 1'b0) $display("FAIL b2b_drain ph_vld got %0b want 0", ph_if.ph_vld);
    else n_pass++;
    n_chk++;
    ph_if.ph_rdy = 1'b0;
  endtask

  task automatic test_stall();
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    do_reset();
    play_hit(2, 16'd130, 16'd50, 16'd60, 16'd70, 16'd80);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak} !== {1'b1, 2'd2, 4'd1, 16'd130})
        $display("FAIL stall_hold%0d got vld %0b ch %0d ring %0d peak %0d want 1/2/1/130", k, ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak);
      else n_pass++;
      n_chk++;
    end
    accept();
    if (ph_if.ph_vld !== 1'b0) $display("FAIL stall_accept ph_vld got %0b want 0", ph_if.ph_vld);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_ovf();
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    do_reset();
    set_ch(0, 16'd120, 1'b1); tick();
    set_ch(0, 16'd0, 1'b0);   tick();
    tick();
    if ({ph_if.ph_vld, ph_if.ph_ring, ph_if.ph_peak, stu_ovf} !== {1'b1, 4'd1, 16'd120, 4'b0000})
      $display("FAIL ovf_first got vld %0b ring %0d peak %0d ovf %b want 1/1/120/0000", ph_if.ph_vld, ph_if.ph_ring, ph_if.ph_peak, stu_ovf);
    else n_pass++;
    n_chk++;
    set_ch(0, 16'd200, 1'b1); tick();
    set_ch(0, 16'd50, 1'b1);  tick();
    set_ch(0, 16'd150, 1'b1); tick();
    set_ch(0, 16'd0, 1'b0);   tick();
    if (stu_ovf !== 4'b0001) $display("FAIL ovf_set got %b want 0001", stu_ovf);
    else n_pass++;
    n_chk++;
    if ({ph_if.ph_ring, ph_if.ph_peak} !== {4'd1, 16'd120})
      $display("FAIL ovf_stable got ring %0d peak %0d want 1/120", ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    ph_if.ph_rdy = 1'b1;
    tick();
    if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak} !== {1'b1, 2'd0, 4'd2, 16'd200})
      $display("FAIL ovf_newest got vld %0b ch %0d ring %0d peak %0d want 1/0/2/200", ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak);
    else n_pass++;
    n_chk++;
    tick();
    ph_if.ph_rdy = 1'b0;
    if (ph_if.ph_vld !== 1'b0) $display("FAIL ovf_drain ph_vld got %0b want 0", ph_if.ph_vld);
    else n_pass++;
    n_chk++;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    if (stu_ovf !== 4'b0000) $display("FAIL ovf_clr got %b want 0000", stu_ovf);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_force_end();
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    do_reset();
    set_ch(1, 16'd120, 1'b1); tick();
    set_ch(1, 16'd50, 1'b1);  tick();
    set_ch(1, 16'd130, 1'b1); tick();
    force_end = 1'b1;
    set_ch(1, 16'd0, 1'b0);   tick();
    force_end = 1'b0;
    if (stu_ring[CW +: CW] !== 4'd2) $display("FAIL force_stu got %0d want 2", stu_ring[CW +: CW]);
    else n_pass++;
    n_chk++;
    tick(); tick();
    if (ph_if.ph_vld !== 1'b0) $display("FAIL force_norec ph_vld got %0b want 0", ph_if.ph_vld);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_reset_mid();
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    do_reset();
    play_hit(2, 16'd130, 16'd50, 16'd60, 16'd70, 16'd80);
    tick();
    if ({ph_if.ph_vld, stu_ring} !== {1'b1, 16'h0100})
      $display("FAIL rstmid_pre got vld %0b ring %h want 1/0100", ph_if.ph_vld, stu_ring);
    else n_pass++;
    n_chk++;
    set_ch(0, 16'd120, 1'b1); tick();
    set_ch(0, 16'd130, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    if ({ph_if.ph_vld, ph_if.ph_ch, ph_if.ph_ring, ph_if.ph_peak, stu_ring, stu_ovf} !== '0)
      $display("FAIL rstmid_zero got vld %0b ring %0d peak %0d stu %h ovf %b want all 0", ph_if.ph_vld, ph_if.ph_ring, ph_if.ph_peak, stu_ring, stu_ovf);
    else n_pass++;
    n_chk++;
    tick();
    set_ch(0, 16'd0, 1'b0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    if ({ph_if.ph_vld, stu_ring} !== '0)
      $display("FAIL rstmid_lost got vld %0b ring %h want 0/0000", ph_if.ph_vld, stu_ring);
    else n_pass++;
    n_chk++;
  endtask

  initial begin
    sm_data = '0; sm_vld = '0; stu_now_hit = '0; stu_now_lock = '0;
    cfg_th = 16'd100; cfg_hyst = 16'd10; cfg_dead = 8'd0;
    force_end = 1'b0; ovf_clr = 1'b0; ph_if.ph_rdy = 1'b0;
    test_reset();
    test_ring();
    test_hyst();
    test_dead();
    test_sat();
    test_back_to_back();
    test_stall();
    test_ovf();
    test_force_end();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d checks done", n_pass, n_chk);
    $fatal(1);
  end
endmodule
